// File: rtl/ser_pkg.sv
// ser_pkg: shared types and constants for the serial operand transmitter
package ser_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int SER_WIDTH   = 4;
    localparam int FRAME_CNT_W = 8;
endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg: parallel-load right-shift register with serial LSB output
module ser_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clr,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);
    logic [WIDTH-1:0] sh;
    // load beats clear so an accept on the last bit chains frames without a gap
    always_ff @(posedge clk)
        if (!rst_n)     sh <= '0;
        else if (load)  sh <= d;
        else if (clr)   sh <= '0;
        else if (shift) sh <= {1'b0, sh[WIDTH-1:1]};
    assign q = sh[0];
endmodule

// File: rtl/serial_operand_tx.sv
// serial_operand_tx: LSB-first operand serializer with sof/eof frame markers
// Optional SER_TX_ABORT_EN adds an abort input that drops the current frame.
module serial_operand_tx
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_cin,
`ifdef SER_TX_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   a_out,
    output logic                   b_out,
    output logic                   cin_out,
    output logic                   bit_valid,
    output logic                   sof,
    output logic                   eof,
    output logic [IDX_W-1:0]       bit_idx,
    output logic [FRAME_CNT_W-1:0] frames_sent
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
    state_t state, state_nxt;
    logic   kill, last, accept, done, go_idle;
`ifdef SER_TX_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif
    assign last     = state == SHIFT && bit_idx == LAST;
    assign in_ready = rst_n && !kill && (state == IDLE || last);
    assign accept   = in_valid && in_ready;
    assign done     = last && !kill;
    assign go_idle  = state_nxt == IDLE;
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb
        state_nxt = accept ? SHIFT : (last || (state == SHIFT && kill)) ? IDLE : state;
    always_comb begin
        bit_valid = state == SHIFT;
        sof       = state == SHIFT && bit_idx == '0;
        eof       = last;
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            bit_idx     <= '0;
            cin_out     <= 1'b0;
            frames_sent <= '0;
        end else begin
            bit_idx     <= (state_nxt == SHIFT && !accept) ? bit_idx + 1'b1 : '0;
            cin_out     <= accept ? in_cin : go_idle ? 1'b0 : cin_out;
            frames_sent <= frames_sent + {{(FRAME_CNT_W-1){1'b0}}, done};
        end
    ser_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk(clk), .rst_n(rst_n), .load(accept), .clr(go_idle),
        .shift(state == SHIFT), .d(in_a), .q(a_out)
    );
    ser_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk(clk), .rst_n(rst_n), .load(accept), .clr(go_idle),
        .shift(state == SHIFT), .d(in_b), .q(b_out)
    );
endmodule

// File: tb/tb_serial_operand_tx.sv
// tb_serial_operand_tx: frame-level reference model plus directed literal checks
module tb_serial_operand_tx;
    localparam int W = 4;
    logic         clk = 0, rst_n = 0, in_valid = 0, in_cin = 0, abort = 0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, a_out, b_out, cin_out, bit_valid, sof, eof;
    logic [1:0]   bit_idx;
    logic [7:0]   frames_sent;
    int           total = 0, bad = 0;
    bit           chk_en = 0;
    bit           act = 0;
    int           k = 0, nfr = 0;
    logic [W-1:0] fa = '0, fb = '0;
    logic         fc = 0, exp_rdy, acc;
    logic [W-1:0] ga, gb, gs, ge, gc, gr;

    always #5 clk = ~clk;

    serial_operand_tx #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SER_TX_ABORT_EN
        .abort(abort),
`endif
        .a_out(a_out), .b_out(b_out), .cin_out(cin_out), .bit_valid(bit_valid),
        .sof(sof), .eof(eof), .bit_idx(bit_idx), .frames_sent(frames_sent)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: an active frame is (captured operands, current bit k); outputs follow directly
    always @(negedge clk) if (chk_en) begin
        exp_rdy = rst_n && (!act || k == W-1) && !abort;
        chk("in_ready", in_ready, exp_rdy);
        chk("a_out", a_out, act ? fa[k] : 1'b0);
        chk("b_out", b_out, act ? fb[k] : 1'b0);
        chk("cin_out", cin_out, act ? fc : 1'b0);
        chk("bit_valid", bit_valid, act);
        chk("sof", sof, act && k == 0);
        chk("eof", eof, act && k == W-1);
        chk("bit_idx", bit_idx, act ? k : 0);
        chk("frames_sent", frames_sent, nfr);
        acc = in_valid && exp_rdy;
        if (!rst_n) begin
            act = 0; k = 0; nfr = 0;
        end else if (act && abort) begin
            act = 0; k = 0;
        end else begin
            if (act && k == W-1) begin
                nfr = (nfr + 1) % 256;
                act = 0;
            end
            if (acc) begin
                act = 1; k = 0; fa = in_a; fb = in_b; fc = in_cin;
            end else if (act) k++;
        end
    end

    initial begin
        tick();
        chk_en = 1;
        tick();
        rst_n = 1;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_frames", frames_sent, 0);
        chk("rst_valid", bit_valid, 0);
        // basic frame, with operand inputs changed right after the accept
        in_a = 4'b1011; in_b = 4'b0110; in_cin = 1; in_valid = 1;
        tick();
        in_valid = 0; in_a = 4'h0; in_cin = 0;
        for (int i = 0; i < W; i++) begin
            ga[i] = a_out; gb[i] = b_out; gs[i] = sof; ge[i] = eof; gc[i] = cin_out;
            tick();
        end
        chk("basic_a", ga, 4'b1011);
        chk("basic_b", gb, 4'b0110);
        chk("basic_sof", gs, 4'b0001);
        chk("basic_eof", ge, 4'b1000);
        chk("basic_cin", gc, 4'b1111);
        chk("basic_idle_a", a_out, 0);
        chk("basic_idle_valid", bit_valid, 0);
        chk("basic_frames", frames_sent, 1);
        // back-to-back frames: second set held valid through the first frame
        in_a = 4'h3; in_b = 4'h9; in_cin = 1; in_valid = 1;
        tick();
        in_a = 4'hF; in_b = 4'h1; in_cin = 0;
        for (int i = 0; i < W; i++) begin
            #1 gr[i] = in_ready;
            tick();
        end
        in_valid = 0;
        chk("b2b_ready", gr, 4'b1000);
        chk("b2b_sof", sof, 1);
        chk("b2b_cin", cin_out, 0);
        chk("b2b_a0", a_out, 1);
        chk("b2b_frames", frames_sent, 2);
        repeat (W) tick();
        chk("b2b_frames_end", frames_sent, 3);
        // reset in the middle of a frame
        in_a = 4'b0111; in_b = 4'b0100; in_cin = 1; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        chk("mid_idx", bit_idx, 2);
        chk("mid_a", a_out, 1);
        rst_n = 0;
        #1 chk("rst_mid_ready", in_ready, 0);
        tick();
        chk("rst_mid_valid", bit_valid, 0);
        chk("rst_mid_a", a_out, 0);
        chk("rst_mid_cin", cin_out, 0);
        chk("rst_mid_frames", frames_sent, 0);
        rst_n = 1;
        #1 chk("rst_mid_rel_ready", in_ready, 1);
        tick();
        // 256 consecutive frames wrap the counter back to 0
        in_valid = 1; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
        tick();
        for (int n = 1; n <= 256*W; n++) begin
            if (n == 256*W) in_valid = 0;
            tick();
            in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
            if (n == 255*W) chk("wrap_255", frames_sent, 255);
        end
        chk("wrap_0", frames_sent, 0);
        chk("wrap_idle", bit_valid, 0);
`ifdef SER_TX_ABORT_EN
        in_a = 4'hA; in_b = 4'h5; in_cin = 1; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        chk("abort_idx", bit_idx, 1);
        abort = 1; in_valid = 1; in_a = 4'hD; in_b = 4'h2; in_cin = 0;
        #1 chk("abort_ready", in_ready, 0);
        tick();
        chk("abort_valid", bit_valid, 0);
        chk("abort_eof", eof, 0);
        chk("abort_frames", frames_sent, 0);
        abort = 0;
        #1 chk("abort_rel_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("abort_new_sof", sof, 1);
        chk("abort_new_a", a_out, 1);
        repeat (W + 1) tick();
        chk("abort_frames_end", frames_sent, 1);
`endif
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
